// File: rtl/logic_unit_arbiter_if.sv
// Request, response and logic-unit bundle for logic_unit_arbiter.
// master = requesters/consumer/logic-unit side, slave = arbiter.
interface logic_unit_arbiter_if #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned OP_CODE_SIZE = 2,
    parameter int unsigned NUM_REQ      = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*DATA_SIZE-1:0]    req_a;
    logic [NUM_REQ*DATA_SIZE-1:0]    req_b;
    logic [NUM_REQ*OP_CODE_SIZE-1:0] req_op;

    logic [DATA_SIZE-1:0]            lu_a;
    logic [DATA_SIZE-1:0]            lu_b;
    logic [OP_CODE_SIZE-1:0]         lu_op;
    logic [DATA_SIZE-1:0]            lu_result;

    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [ID_W-1:0]                 rsp_id;
    logic [DATA_SIZE-1:0]            rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, lu_result,
        input  req_ready, lu_a, lu_b, lu_op, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, lu_result,
        output req_ready, lu_a, lu_b, lu_op, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency logic unit among NUM_REQ requesters;
// tags each issued op with its requester ID and returns results in order through a response FIFO.
module logic_unit_arbiter #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned OP_CODE_SIZE = 2,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LU_LATENCY   = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_al_in,
    logic_unit_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(LU_LATENCY + 1);

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [DATA_SIZE-1:0] result;
    } rsp_t;

    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic [LU_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [LU_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    rsp_t                            fifo_mem_q [FIFO_DEPTH];
    logic [IDX_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d;

    logic [INF_W-1:0]   inflight_c;
    logic               credit_c;
    logic [NUM_REQ-1:0] rot_valid_c;
    logic               grant_vld_c;
    logic [ID_W-1:0]    grant_id_c;
    logic               push_c;
    logic               pop_c;
    logic               rsp_valid_c;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + IDX_W'(1);
    endfunction

    // Credit counts FIFO occupancy plus ops still travelling through the logic unit.
    always_comb begin
        inflight_c = '0;
        for (int unsigned s = 0; s < LU_LATENCY; s++) begin
            inflight_c = inflight_c + INF_W'(tag_vld_q[s]);
        end
    end

    assign credit_c = reset_al_in && ((32'(count_q) + 32'(inflight_c)) < FIFO_DEPTH);

    // Search rotated so that bit 0 corresponds to the current priority pointer.
    always_comb begin
        rot_valid_c = NUM_REQ'({bus.req_valid, bus.req_valid} >> ptr_q);
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld_c && rot_valid_c[k]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = ID_W'((k + 32'(ptr_q)) % NUM_REQ);
            end
        end
        grant_vld_c = grant_vld_c & credit_c;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.lu_a      = '0;
        bus.lu_b      = '0;
        bus.lu_op     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_vld_c && (grant_id_c == ID_W'(k))) begin
                bus.req_ready[k] = 1'b1;
                bus.lu_a         = bus.req_a[k*DATA_SIZE +: DATA_SIZE];
                bus.lu_b         = bus.req_b[k*DATA_SIZE +: DATA_SIZE];
                bus.lu_op        = bus.req_op[k*OP_CODE_SIZE +: OP_CODE_SIZE];
            end
        end
    end

    // Pointer, tag pipeline and FIFO bookkeeping next-state.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld_c) begin
            ptr_d = (32'(grant_id_c) == NUM_REQ - 1) ? '0 : grant_id_c + ID_W'(1);
        end

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = grant_vld_c;
        tag_id_d[0]  = grant_id_c;
        for (int unsigned s = 1; s < LU_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        wr_ptr_d = push_c ? idx_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_c  ? idx_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    assign push_c      = tag_vld_q[LU_LATENCY-1];
    assign rsp_valid_c = (count_q != '0);
    assign pop_c       = rsp_valid_c && bus.rsp_ready;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= '{id: tag_id_q[LU_LATENCY-1], result: bus.lu_result};
        end
    end

    always_comb begin
        bus.rsp_valid  = rsp_valid_c;
        bus.rsp_id     = '0;
        bus.rsp_result = '0;
        if (rsp_valid_c) begin
            bus.rsp_id     = fifo_mem_q[rd_ptr_q].id;
            bus.rsp_result = fifo_mem_q[rd_ptr_q].result;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter with a behavioural 2-cycle logic unit,
// a round-robin/credit reference model and a decoupled response monitor.
module tb_logic_unit_arbiter;
    localparam int unsigned DATA_SIZE    = 8;
    localparam int unsigned OP_CODE_SIZE = 2;
    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned LU_LATENCY   = 2;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned ID_W         = $clog2(NUM_REQ);
    localparam int          CLK_P        = 10;

    typedef struct {
        logic [ID_W-1:0]      id;
        logic [DATA_SIZE-1:0] res;
        time                  t;
    } exp_t;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    logic_unit_arbiter_if #(.DATA_SIZE(DATA_SIZE), .OP_CODE_SIZE(OP_CODE_SIZE), .NUM_REQ(NUM_REQ)) bus ();

    logic_unit_arbiter #(
        .DATA_SIZE(DATA_SIZE), .OP_CODE_SIZE(OP_CODE_SIZE), .NUM_REQ(NUM_REQ),
        .LU_LATENCY(LU_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset_al_in(rst_n),
        .bus(bus)
    );

    logic                    v  [NUM_REQ];
    logic [DATA_SIZE-1:0]    a  [NUM_REQ];
    logic [DATA_SIZE-1:0]    b  [NUM_REQ];
    logic [OP_CODE_SIZE-1:0] op [NUM_REQ];
    logic                    rsp_rdy;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]                           = v[i];
            bus.req_a[i*DATA_SIZE +: DATA_SIZE]        = a[i];
            bus.req_b[i*DATA_SIZE +: DATA_SIZE]        = b[i];
            bus.req_op[i*OP_CODE_SIZE +: OP_CODE_SIZE] = op[i];
        end
    end
    assign bus.rsp_ready = rsp_rdy;

    function automatic logic [DATA_SIZE-1:0] lu_fn(input logic [DATA_SIZE-1:0] x,
                                                   input logic [DATA_SIZE-1:0] y,
                                                   input logic [OP_CODE_SIZE-1:0] o);
        case (o)
            2'b00:   return x | y;
            2'b01:   return x ^ y;
            2'b10:   return x & y;
            default: return ~x;
        endcase
    endfunction

    // Behavioural logic unit: registered inputs, registered result, sync reset.
    logic [DATA_SIZE-1:0]    lu_a_q, lu_b_q, lu_res_q;
    logic [OP_CODE_SIZE-1:0] lu_op_q;
    always @(posedge clk) begin
        if (!rst_n) begin
            lu_a_q <= '0; lu_b_q <= '0; lu_op_q <= '0; lu_res_q <= '0;
        end else begin
            lu_a_q   <= bus.lu_a;
            lu_b_q   <= bus.lu_b;
            lu_op_q  <= bus.lu_op;
            lu_res_q <= lu_fn(lu_a_q, lu_b_q, lu_op_q);
        end
    end
    assign bus.lu_result = lu_res_q;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    exp_t               sbq[$];
    int                 ptr_m, issued, popped, grants, last_grant, g;
    logic [NUM_REQ-1:0] acc_vec, exp_rdy;
    exp_t               m_e;

    initial begin
        ptr_m = 0; issued = 0; popped = 0; grants = 0; last_grant = -1; acc_vec = '0;
    end

    // Reference model: round-robin over valid requesters, credit = accepted minus consumed.
    always @(negedge clk) begin
        if (!rst_n) begin
            check(bus.req_ready == '0, "ready_in_reset", 32'(bus.req_ready), 0);
            check(bus.rsp_valid == 1'b0, "rsp_valid_in_reset", 32'(bus.rsp_valid), 0);
            ptr_m = 0; issued = 0; acc_vec = '0;
            sbq.delete();
        end else begin
            exp_rdy = '0;
            g = -1;
            if (issued - popped < int'(FIFO_DEPTH)) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && v[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check(bus.req_ready === exp_rdy, "req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            acc_vec = bus.req_ready & bus.req_valid;
            if (g >= 0) begin
                check({bus.lu_a, bus.lu_b, bus.lu_op} === {a[g], b[g], op[g]}, "lu_operands",
                      32'({bus.lu_a, bus.lu_b, bus.lu_op}), 32'({a[g], b[g], op[g]}));
                sbq.push_back('{id: ID_W'(g), res: lu_fn(a[g], b[g], op[g]), t: $time});
                issued++;
                grants++;
                last_grant = g;
                ptr_m = (g + 1) % NUM_REQ;
            end else begin
                check({bus.lu_a, bus.lu_b, bus.lu_op} == '0, "lu_idle_zero",
                      32'({bus.lu_a, bus.lu_b, bus.lu_op}), 0);
            end
        end
    end

    // Response monitor: pops the scoreboard on every accepted response.
    always @(negedge clk) begin
        if (!rst_n) begin
            popped <= 0;
        end else if (!bus.rsp_valid) begin
            check({bus.rsp_id, bus.rsp_result} == '0, "idle_rsp_zero", 32'({bus.rsp_id, bus.rsp_result}), 0);
        end else if (rsp_rdy) begin
            check(sbq.size() != 0, "unexpected_rsp", 32'({bus.rsp_id, bus.rsp_result}), 0);
            if (sbq.size() != 0) begin
                m_e = sbq.pop_front();
                check(bus.rsp_id === m_e.id, "rsp_id", 32'(bus.rsp_id), 32'(m_e.id));
                check(bus.rsp_result === m_e.res, "rsp_result", 32'(bus.rsp_result), 32'(m_e.res));
                check(($time - m_e.t) >= time'((LU_LATENCY + 1) * CLK_P), "rsp_latency",
                      32'($time - m_e.t), 32'((LU_LATENCY + 1) * CLK_P));
            end
            popped <= popped + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acc_vec[i]) v[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DATA_SIZE-1:0] x, input logic [DATA_SIZE-1:0] y,
                           input logic [OP_CODE_SIZE-1:0] o);
        v[i] = 1'b1; a[i] = x; b[i] = y; op[i] = o;
    endtask

    task automatic set_rand(input int i);
        set_req(i, DATA_SIZE'($urandom), DATA_SIZE'($urandom), OP_CODE_SIZE'($urandom));
    endtask

    task automatic refresh_all();
        for (int i = 0; i < NUM_REQ; i++) if (!v[i]) set_rand(i);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) v[i] = 1'b0;
    endtask

    task automatic wait_acc(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (!acc_vec[i] && n < 20);
        check(acc_vec[i], "wait_accept", 32'(acc_vec), 32'(1 << i));
        @(posedge clk); #1;
        for (int j = 0; j < NUM_REQ; j++) if (acc_vec[j]) v[j] = 1'b0;
    endtask

    task automatic drain();
        int n;
        clear_all();
        rsp_rdy = 1'b1;
        n = 0;
        while ((sbq.size() != 0 || bus.rsp_valid) && n < 60) begin
            tick();
            n++;
        end
        check(sbq.size() == 0, "drain_empty", 32'(sbq.size()), 0);
    endtask

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int g0;
        rst_n   = 1'b0;
        rsp_rdy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_rand(i);
        repeat (3) @(posedge clk);
        #1;
        check(bus.req_ready == '0, "reset_ready", 32'(bus.req_ready), 0);
        check({bus.lu_a, bus.lu_b, bus.lu_op} == '0, "reset_lu", 32'({bus.lu_a, bus.lu_b, bus.lu_op}), 0);
        clear_all();
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        tick();

        // Lone requester 2: OR, three-cycle issue-to-response latency.
        set_req(2, 8'h0F, 8'hF0, 2'b00);
        wait_acc(2);
        check(acc_vec == NUM_REQ'(4'b0100), "t1_grant", 32'(acc_vec), 32'h4);
        lat = 0;
        do begin
            @(negedge clk); #2; lat++;
        end while (!bus.rsp_valid && lat < 10);
        check(lat == 3, "t1_latency", 32'(lat), 3);
        check(bus.rsp_id == ID_W'(2), "t1_id", 32'(bus.rsp_id), 2);
        check(bus.rsp_result == 8'hFF, "t1_result", 32'(bus.rsp_result), 32'hFF);
        tick();

        // XOR / AND / NOT from different requesters.
        set_req(0, 8'hFF, 8'h0F, 2'b01);
        set_req(1, 8'h3C, 8'h0F, 2'b10);
        set_req(3, 8'hA5, 8'h00, 2'b11);
        repeat (4) tick();
        drain();

        // All valid, free-flowing responses: one grant per cycle.
        refresh_all();
        g0 = grants;
        repeat (20) begin tick(); refresh_all(); end
        check(grants - g0 == 20, "t3_throughput", 32'(grants - g0), 20);
        drain();

        // All valid, responses stalled: credit limit then resume.
        rsp_rdy = 1'b0;
        refresh_all();
        g0 = grants;
        repeat (10) begin tick(); refresh_all(); end
        check(grants - g0 == int'(FIFO_DEPTH), "t4_credit_grants", 32'(grants - g0), FIFO_DEPTH);
        check(bus.req_ready == '0, "t4_ready_blocked", 32'(bus.req_ready), 0);
        rsp_rdy = 1'b1;
        repeat (12) begin tick(); refresh_all(); end
        drain();

        // Pointer at 2 with requesters 1 and 3 pending; then a single persistent requester.
        set_rand(1);
        wait_acc(1);
        set_rand(1);
        set_rand(3);
        tick();
        check(last_grant == 3, "t5_first", 32'(last_grant), 3);
        tick();
        check(last_grant == 1, "t5_second", 32'(last_grant), 1);
        g0 = grants;
        set_rand(0);
        repeat (6) begin tick(); if (!v[0]) set_rand(0); end
        check(grants - g0 == 6, "t5_single", 32'(grants - g0), 6);
        drain();

        // Reset with two ops in flight and one buffered.
        rsp_rdy = 1'b0;
        g0 = grants;
        set_rand(0);
        repeat (3) begin tick(); if (!v[0]) set_rand(0); end
        clear_all();
        check(grants - g0 == 3, "t6_issued", 32'(grants - g0), 3);
        check(bus.rsp_valid == 1'b1, "t6_buffered", 32'(bus.rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check(bus.rsp_valid == 1'b0, "t6_async_clear", 32'(bus.rsp_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        repeat (8) tick();
        check(bus.rsp_valid == 1'b0, "t6_no_stale", 32'(bus.rsp_valid), 0);
        refresh_all();
        tick();
        check(last_grant == 0, "t6_ptr_reset", 32'(last_grant), 0);
        drain();

        // Randomised traffic with drops and backpressure.
        repeat (300) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (v[i]) begin
                    if ($urandom_range(15) == 0) v[i] = 1'b0;
                end else if ($urandom_range(99) < 50) begin
                    set_rand(i);
                end
            end
            rsp_rdy = ($urandom_range(99) < 70);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
